rotate_amount_finder: RTL and testbench

Multi-cycle inverse of the 32-bit barrel rotator. Given a source word and a rotated word, it finds the smallest rotate amount in a requested direction that maps the source onto the rotated word, or reports that no such amount exists. It sits beside the rotator in the datapath and is used for rotate-operand recovery and self-check. It searches one bit position per cycle behind a valid/ready handshake on both sides.

---
 rtl/rot_pkg.sv | 17 +
 rtl/rot1.sv | 21 ++
 rtl/rotate_amount_finder.sv | 136 +++++++++++++
 tb/tb_rotate_amount_finder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared constants and state encoding for the rotator family
// (the finder now, the sequential rotator later).
package rot_pkg;

    localparam int WIDTH = 32;
    localparam int AMT_W = $clog2(WIDTH);

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/rot1.sv
// Combinational single-position rotate: right moves bit 0 to the MSB,
// left moves the MSB to bit 0.
module rot1
    import rot_pkg::*;
#(
    parameter int WIDTH = rot_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] w,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        if (d == DIR_RIGHT) begin
            q = {w[0], w[WIDTH-1:1]};
        end else begin
            q = {w[WIDTH-2:0], w[WIDTH-1]};
        end
    end

endmodule

// File: rtl/rotate_amount_finder.sv
// Finds the smallest rotate amount mapping a onto y, testing one amount per
// cycle; valid/ready handshakes on request and result.
module rotate_amount_finder
    import rot_pkg::*;
#(
    parameter int WIDTH = rot_pkg::WIDTH,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] y,
    input  logic             direction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AMT_W-1:0] amt,
    output logic             found
);

    localparam logic [AMT_W-1:0] LAST_IDX = AMT_W'(WIDTH - 1);

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0] r_w;
    logic [WIDTH-1:0] r_t;
    logic             r_d;
    logic [AMT_W-1:0] r_idx;
    logic [AMT_W-1:0] r_amt;
    logic             r_found;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_rot;
    logic             w_accept;
    logic             w_match;
    logic             w_exhausted;

    rot1 #(
        .WIDTH (WIDTH)
    ) u_rot1 (
        .w (r_w),
        .d (r_d),
        .q (w_rot)
    );

    assign w_accept    = in_valid && (r_state == IDLE);
    assign w_match     = (r_w == r_t);
    assign w_exhausted = (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = SEARCH;
                end
            end
            SEARCH: begin
                if (w_match || w_exhausted) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Search datapath; idx saturates at WIDTH-1, so amt can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w         <= '0;
            r_t         <= '0;
            r_d         <= DIR_LEFT;
            r_idx       <= '0;
            r_amt       <= '0;
            r_found     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_w   <= a;
                        r_t   <= y;
                        r_d   <= direction;
                        r_idx <= '0;
                    end
                end
                SEARCH: begin
                    if (w_match) begin
                        r_amt       <= r_idx;
                        r_found     <= 1'b1;
                        r_out_valid <= 1'b1;
                    end else if (w_exhausted) begin
                        r_amt       <= '0;
                        r_found     <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_w   <= w_rot;
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign amt       = r_amt;
    assign found     = r_found;

endmodule

// File: tb/tb_rotate_amount_finder.sv
// Scoreboard bench for rotate_amount_finder: an independent shift-based model
// predicts amount, found flag and latency for every accepted request.
module tb_rotate_amount_finder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] y;
    logic        direction;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  amt;
    logic        found;

    typedef struct {
        logic [4:0] amt;
        logic       found;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   tests;
    int   fails;

    rotate_amount_finder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .y         (y),
        .direction (direction),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .amt       (amt),
        .found     (found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] my, input logic md);
        exp_t        e;
        logic [31:0] r;
        e.amt   = 5'd0;
        e.found = 1'b0;
        e.lat   = 32;
        for (int k = 31; k >= 0; k--) begin
            if (md) r = (ma >> k) | (ma << (32 - k));
            else    r = (ma << k) | (ma >> (32 - k));
            if (k == 0) r = ma;
            if (r == my) begin
                e.amt   = 5'(k);
                e.found = 1'b1;
                e.lat   = k + 1;
            end
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] ia, input logic [31:0] iy, input logic id);
        int guard;
        guard = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL issue_ready: in_ready=%b required 1", in_ready);
        end
        a         = ia;
        y         = iy;
        direction = id;
        in_valid  = 1'b1;
        @(posedge clk);
        sb.push_back(model(ia, iy, id));
        #1 in_valid = 1'b0;
    endtask

    task automatic collect(input string name);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, cyc);
        end
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("[TB] FAIL %s_scoreboard: queue size=0 required >0", name);
        end else begin
            e = sb.pop_front();
            if (amt !== e.amt) begin
                fails++;
                $display("[TB] FAIL %s_amt: got %0d required %0d", name, amt, e.amt);
            end
            tests++;
            if (found !== e.found) begin
                fails++;
                $display("[TB] FAIL %s_found: got %b required %b", name, found, e.found);
            end
            tests++;
            if (cyc != e.lat) begin
                fails++;
                $display("[TB] FAIL %s_latency: got %0d required %0d", name, cyc, e.lat);
            end
        end
        if (out_ready === 1'b1) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("[TB] FAIL %s_release: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || amt !== 5'd0 || found !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b amt=%0d found=%b required 1 0 0 0",
                     in_ready, out_valid, amt, found);
        end
    endtask

    task automatic test_basic();
        issue(32'h0000_0001, 32'h8000_0000, 1'b1); collect("right1");
        issue(32'h1234_5678, 32'h1234_5678, 1'b0); collect("identity");
        issue(32'h0000_00F0, 32'h0000_0F00, 1'b0); collect("dir_left");
        issue(32'h0000_00F0, 32'h0000_0F00, 1'b1); collect("dir_right");
        issue(32'h0000_0001, 32'h8000_0000, 1'b0); collect("left31");
    endtask

    task automatic test_no_match();
        issue(32'h0000_0001, 32'h0000_0003, 1'b0); collect("nomatch");
        issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0); collect("periodic_l");
        issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b1); collect("periodic_r");
    endtask

    task automatic test_random();
        logic [31:0] ra;
        logic [31:0] ry;
        logic        rd;
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rd = 1'($urandom_range(0, 1));
            ry = (i == 5) ? $urandom : ((ra << (i * 5)) | (ra >> (32 - i * 5)));
            if (i == 0) ry = ra;
            issue(ra, ry, rd);
            collect("random");
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        issue(32'h0000_00F0, 32'h0000_0F00, 1'b0);
        collect("bp_first");
        a         = 32'hAAAA_AAAA;
        y         = 32'h5555_5555;
        direction = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1 || amt !== 5'd4 || found !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL bp_hold: out_valid=%b amt=%0d found=%b in_ready=%b required 1 4 1 0",
                         out_valid, amt, found, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL bp_handshake: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        sb.push_back(model(32'hAAAA_AAAA, 32'h5555_5555, 1'b0));
        #1 in_valid = 1'b0;
        collect("bp_next");
    endtask

    task automatic test_async_reset();
        issue(32'h0000_0001, 32'h0010_0000, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || amt !== 5'd0 || found !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL async_reset: out_valid=%b amt=%0d found=%b in_ready=%b required 0 0 0 1",
                     out_valid, amt, found, in_ready);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_drop: out_valid=%b required 0", out_valid);
        end
        issue(32'h0000_00F0, 32'h0000_0F00, 1'b1);
        collect("after_reset");
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        y         = '0;
        direction = 1'b0;
        out_ready = 1'b1;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_no_match();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
